// File: rtl/esm_buffer_scheduler_pkg.sv
// Shared types and helpers for the ESM instruction-buffer slot scheduler.
package esm_buffer_scheduler_pkg;

  // Flush sequencing: normal operation, wait for in-flight slots, wipe table.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  // True when n is a non-zero power of two (pointer wrap relies on this).
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/esm_buffer_scheduler_if.sv
// Handshake bundle between fetch/core (master) and the slot scheduler (slave).
interface esm_buffer_scheduler_if #(
  parameter int bs = 16
);
  localparam int IDX_W = $clog2(bs);

  // Allocation side (fetch)
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] wr_idx;
  // Issue side (core)
  logic             iss_valid;
  logic             iss_ready;
  logic [IDX_W-1:0] iss_idx;
  // Completion side (core)
  logic             retire_en;
  logic [IDX_W-1:0] retire_idx;
  logic             retire_err;
  // Flush control
  logic             flush_req;
  logic             flush_done;
  // Status
  logic [0:bs-1]    valid_entries;
  logic [IDX_W:0]   occupancy;

  modport master (
    output in_valid, iss_ready, retire_en, retire_idx, flush_req,
    input  in_ready, wr_idx, iss_valid, iss_idx, retire_err, flush_done,
           valid_entries, occupancy
  );

  modport slave (
    input  in_valid, iss_ready, retire_en, retire_idx, flush_req,
    output in_ready, wr_idx, iss_valid, iss_idx, retire_err, flush_done,
           valid_entries, occupancy
  );

endinterface

// File: rtl/esm_buffer_scheduler_slot_table.sv
// Per-slot valid/issued bit arrays with set, issue-mark, clear and wipe ports.
// Also reports the popcount of valid slots and whether any slot is in flight.
module esm_slot_table #(
  parameter int bs = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_set_en,
  input  logic [$clog2(bs)-1:0]  i_set_idx,
  input  logic                   i_iss_en,
  input  logic [$clog2(bs)-1:0]  i_iss_idx,
  input  logic                   i_clr_en,
  input  logic [$clog2(bs)-1:0]  i_clr_idx,
  input  logic                   i_clear_all,
  output logic [0:bs-1]          o_valid,
  output logic [0:bs-1]          o_issued,
  output logic [$clog2(bs):0]    o_count,
  output logic                   o_any_issued
);
  localparam int IDX_W = $clog2(bs);
  localparam int CNT_W = IDX_W + 1;

  logic [0:bs-1] r_valid;
  logic [0:bs-1] r_issued;
  logic [CNT_W-1:0] w_count;

  // Update slot bits; the three per-slot ops never legally hit the same slot.
  // NOTE: these bit arrays are tiny flops, not RAM, so they take the async
  // reset; a reset mid-operation must discard every entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_issued <= '0;
    end else if (i_clear_all) begin
      r_valid  <= '0;
      r_issued <= '0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (i_set_en && (i_set_idx == IDX_W'(i))) begin
          r_valid[i]  <= 1'b1;
          r_issued[i] <= 1'b0;
        end
        if (i_iss_en && (i_iss_idx == IDX_W'(i))) begin
          r_issued[i] <= 1'b1;
        end
        if (i_clr_en && (i_clr_idx == IDX_W'(i))) begin
          r_valid[i]  <= 1'b0;
          r_issued[i] <= 1'b0;
        end
      end
    end
  end

  // Population count of allocated slots.
  // NOTE: blocking accumulation is correct here because this is purely
  // combinational; the zero default also keeps the block latch-free.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < bs; i++) begin
      w_count = w_count + CNT_W'(r_valid[i]);
    end
  end

  assign o_valid      = r_valid;
  assign o_issued     = r_issued;
  assign o_count      = w_count;
  assign o_any_issued = |r_issued;

endmodule

// File: rtl/esm_buffer_scheduler.sv
// ESM instruction-buffer slot scheduler: in-order allocate and issue,
// out-of-order retire, and a drain-then-clear flush sequence.
module esm_buffer_scheduler
  import esm_buffer_scheduler_pkg::*;
#(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  esm_buffer_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(bs);

  // Pointer wrap is a plain binary rollover, so depth must be a power of two.
  if (!is_pow2(bs) || (bs < 2) || (Instruction_word_size < 1)) begin : g_bad_params
    $error("esm_buffer_scheduler: bs must be a power of two >= 2");
  end

  sched_state_t     r_state;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_iss_ptr;
  logic             r_flush_done;
  logic             r_retire_err;
  logic             r_out_en;

  logic [0:bs-1]    w_valid;
  logic [0:bs-1]    w_issued;
  logic [IDX_W:0]   w_count;
  logic             w_any_issued;
  logic             w_run;
  logic             w_in_ready;
  logic             w_iss_valid;
  logic             w_alloc;
  logic             w_issue;
  logic             w_retire_ok;
  logic             w_retire_bad;
  logic             w_clear_all;

  // Handshakes are only offered in RUN, and not until the first clock after
  // reset release (r_out_en); all terms come from registered state.
  assign w_run        = r_out_en && (r_state == ST_RUN);
  assign w_in_ready   = w_run && !w_valid[r_wr_ptr];
  assign w_iss_valid  = w_run && w_valid[r_iss_ptr] && !w_issued[r_iss_ptr];
  assign w_alloc      = bus.in_valid && w_in_ready;
  assign w_issue      = w_iss_valid && bus.iss_ready;
  assign w_retire_ok  = bus.retire_en && w_valid[bus.retire_idx] && w_issued[bus.retire_idx];
  assign w_retire_bad = bus.retire_en && !w_retire_ok;
  assign w_clear_all  = (r_state == ST_CLEAR);

  esm_slot_table #(.bs(bs)) u_slot_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (w_alloc),
    .i_set_idx    (r_wr_ptr),
    .i_iss_en     (w_issue),
    .i_iss_idx    (r_iss_ptr),
    .i_clr_en     (w_retire_ok),
    .i_clr_idx    (bus.retire_idx),
    .i_clear_all  (w_clear_all),
    .o_valid      (w_valid),
    .o_issued     (w_issued),
    .o_count      (w_count),
    .o_any_issued (w_any_issued)
  );

  // Flush FSM, pointer advance and one-cycle pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_wr_ptr     <= '0;
      r_iss_ptr    <= '0;
      r_flush_done <= 1'b0;
      r_retire_err <= 1'b0;
      r_out_en     <= 1'b0;
    end else begin
      r_out_en     <= 1'b1;
      r_flush_done <= 1'b0;
      r_retire_err <= w_retire_bad;
      case (r_state)
        ST_RUN: begin
          if (w_alloc) r_wr_ptr  <= r_wr_ptr + IDX_W'(1);
          if (w_issue) r_iss_ptr <= r_iss_ptr + IDX_W'(1);
          if (bus.flush_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Unissued entries are simply dropped; only in-flight ones are waited on.
          if (!w_any_issued) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_wr_ptr     <= '0;
          r_iss_ptr    <= '0;
          r_flush_done <= 1'b1;
          r_state      <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.wr_idx        = r_wr_ptr;
  assign bus.iss_valid     = w_iss_valid;
  assign bus.iss_idx       = r_iss_ptr;
  assign bus.valid_entries = w_valid;
  assign bus.occupancy     = w_count;
  assign bus.flush_done    = r_flush_done;
  assign bus.retire_err    = r_retire_err;

endmodule

// File: tb/tb_esm_buffer_scheduler.sv
// Directed bench for esm_buffer_scheduler: a bs=4 instance for the main
// scenarios and a bs=16 instance for a long wrap-around run.
module tb_esm_buffer_scheduler;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  esm_buffer_scheduler_if #(.bs(4))  if_a ();
  esm_buffer_scheduler_if #(.bs(16)) if_b ();

  esm_buffer_scheduler #(.Instruction_word_size(32), .bs(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  esm_buffer_scheduler #(.Instruction_word_size(32), .bs(16)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    if_a.in_valid   = 1'b0;
    if_a.iss_ready  = 1'b0;
    if_a.retire_en  = 1'b0;
    if_a.retire_idx = '0;
    if_a.flush_req  = 1'b0;
    if_b.in_valid   = 1'b0;
    if_b.iss_ready  = 1'b0;
    if_b.retire_en  = 1'b0;
    if_b.retire_idx = '0;
    if_b.flush_req  = 1'b0;

    // ---- Reset state ----
    #12;
    check("rst_in_ready",   32'(if_a.in_ready), 32'd0);
    check("rst_iss_valid",  32'(if_a.iss_valid), 32'd0);
    check("rst_occupancy",  32'(if_a.occupancy), 32'd0);
    check("rst_valid",      32'(if_a.valid_entries), 32'd0);
    check("rst_flush_done", 32'(if_a.flush_done), 32'd0);
    check("rst_retire_err", 32'(if_a.retire_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre", 32'(if_a.in_ready), 32'd0);
    tick();
    check("rel_in_ready", 32'(if_a.in_ready), 32'd1);
    check("rel_wr_idx",   32'(if_a.wr_idx), 32'd0);

    // ---- Fill all four slots with issue stalled ----
    if_a.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_wr_idx_%0d", i), 32'(if_a.wr_idx), 32'(i));
      tick();
    end
    if_a.in_valid = 1'b0;
    check("full_valid",     32'(if_a.valid_entries), 32'(4'b1111));
    check("full_occupancy", 32'(if_a.occupancy), 32'd4);
    check("full_in_ready",  32'(if_a.in_ready), 32'd0);
    check("full_wr_idx",    32'(if_a.wr_idx), 32'd0);
    check("full_iss_valid", 32'(if_a.iss_valid), 32'd1);

    // ---- Issue all four in order ----
    if_a.iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("iss_valid_%0d", i), 32'(if_a.iss_valid), 32'd1);
      check($sformatf("iss_idx_%0d", i),   32'(if_a.iss_idx), 32'(i));
      tick();
    end
    if_a.iss_ready = 1'b0;
    check("iss_done_valid", 32'(if_a.iss_valid), 32'd0);
    check("iss_done_idx",   32'(if_a.iss_idx), 32'd0);

    // ---- Out-of-order retire of slot 2: wr_ptr still blocked by slot 0 ----
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd2;
    tick();
    if_a.retire_en  = 1'b0;
    check("ret2_valid",     32'(if_a.valid_entries), 32'(4'b1101));
    check("ret2_occupancy", 32'(if_a.occupancy), 32'd3);
    check("ret2_in_ready",  32'(if_a.in_ready), 32'd0);
    check("ret2_err",       32'(if_a.retire_err), 32'd0);

    // ---- Retire slot 0: allocation resumes at slot 0 (wrap) ----
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd0;
    tick();
    if_a.retire_en  = 1'b0;
    check("ret0_valid",    32'(if_a.valid_entries), 32'(4'b0101));
    check("ret0_in_ready", 32'(if_a.in_ready), 32'd1);
    check("ret0_wr_idx",   32'(if_a.wr_idx), 32'd0);

    // ---- Same-cycle allocate (slot 0) and retire (slot 1) ----
    if_a.in_valid   = 1'b1;
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd1;
    tick();
    if_a.in_valid   = 1'b0;
    if_a.retire_en  = 1'b0;
    check("alloc_ret_valid",     32'(if_a.valid_entries), 32'(4'b1001));
    check("alloc_ret_occupancy", 32'(if_a.occupancy), 32'd2);
    check("alloc_ret_wr_idx",    32'(if_a.wr_idx), 32'd1);
    check("alloc_ret_iss_valid", 32'(if_a.iss_valid), 32'd1);

    // ---- Illegal retires: free slot 2, then unissued slot 0 ----
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd2;
    tick();
    if_a.retire_en  = 1'b0;
    check("err_free_pulse", 32'(if_a.retire_err), 32'd1);
    check("err_free_valid", 32'(if_a.valid_entries), 32'(4'b1001));
    tick();
    check("err_free_clear", 32'(if_a.retire_err), 32'd0);
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd0;
    tick();
    if_a.retire_en  = 1'b0;
    check("err_uniss_pulse", 32'(if_a.retire_err), 32'd1);
    check("err_uniss_valid", 32'(if_a.valid_entries), 32'(4'b1001));
    check("err_uniss_occ",   32'(if_a.occupancy), 32'd2);

    // ---- Build: slots 0,1 issued, slot 2 allocated but unissued ----
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd3;
    tick();
    if_a.retire_en  = 1'b0;
    check("prep_valid_a", 32'(if_a.valid_entries), 32'(4'b1000));
    if_a.in_valid  = 1'b1;
    if_a.iss_ready = 1'b1;
    tick();
    tick();
    if_a.in_valid  = 1'b0;
    if_a.iss_ready = 1'b0;
    check("prep_valid_b", 32'(if_a.valid_entries), 32'(4'b1110));
    check("prep_iss_idx", 32'(if_a.iss_idx), 32'd2);
    check("prep_wr_idx",  32'(if_a.wr_idx), 32'd3);
    check("prep_occ",     32'(if_a.occupancy), 32'd3);

    // ---- Flush: DRAIN blocks handshakes, waits for slots 0 and 1 ----
    if_a.flush_req = 1'b1;
    tick();
    if_a.flush_req = 1'b0;
    if_a.in_valid  = 1'b1;
    if_a.iss_ready = 1'b1;
    check("drain_in_ready",  32'(if_a.in_ready), 32'd0);
    check("drain_iss_valid", 32'(if_a.iss_valid), 32'd0);
    if_a.retire_en  = 1'b1;
    if_a.retire_idx = 2'd0;
    tick();
    check("drain_ret0_valid", 32'(if_a.valid_entries), 32'(4'b0110));
    check("drain_no_alloc",   32'(if_a.wr_idx), 32'd3);
    check("drain_no_issue",   32'(if_a.iss_idx), 32'd2);
    if_a.in_valid   = 1'b0;
    if_a.iss_ready  = 1'b0;
    if_a.retire_idx = 2'd1;
    tick();
    if_a.retire_en  = 1'b0;
    check("drain_ret1_valid", 32'(if_a.valid_entries), 32'(4'b0010));
    check("drain_ret1_err",   32'(if_a.retire_err), 32'd0);
    tick();
    check("clear_flush_done", 32'(if_a.flush_done), 32'd0);
    check("clear_in_ready",   32'(if_a.in_ready), 32'd0);
    tick();
    check("flushed_valid",  32'(if_a.valid_entries), 32'd0);
    check("flushed_occ",    32'(if_a.occupancy), 32'd0);
    check("flushed_wr_idx", 32'(if_a.wr_idx), 32'd0);
    check("flushed_iss",    32'(if_a.iss_idx), 32'd0);
    check("flushed_done",   32'(if_a.flush_done), 32'd1);
    check("flushed_ready",  32'(if_a.in_ready), 32'd1);
    tick();
    check("flushed_done_pulse", 32'(if_a.flush_done), 32'd0);

    // ---- Empty buffer, flush_req held: back-to-back flushes ----
    if_a.flush_req = 1'b1;
    tick();
    tick();
    tick();
    check("empty_flush1_done", 32'(if_a.flush_done), 32'd1);
    tick();
    if_a.flush_req = 1'b0;
    check("empty_flush2_drain", 32'(if_a.in_ready), 32'd0);
    tick();
    tick();
    check("empty_flush2_done", 32'(if_a.flush_done), 32'd1);
    tick();
    check("empty_flush_idle", 32'(if_a.flush_done), 32'd0);
    check("empty_flush_ready", 32'(if_a.in_ready), 32'd1);

    // ---- Async reset in the middle of DRAIN ----
    if_a.in_valid = 1'b1;
    tick();
    if_a.in_valid  = 1'b0;
    if_a.iss_ready = 1'b1;
    tick();
    if_a.iss_ready = 1'b0;
    if_a.in_valid  = 1'b1;
    tick();
    if_a.in_valid = 1'b0;
    check("pre_rst_valid", 32'(if_a.valid_entries), 32'(4'b1100));
    if_a.flush_req = 1'b1;
    tick();
    if_a.flush_req = 1'b0;
    tick();
    check("pre_rst_drain", 32'(if_a.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(if_a.valid_entries), 32'd0);
    check("mid_rst_occ",    32'(if_a.occupancy), 32'd0);
    check("mid_rst_wr_idx", 32'(if_a.wr_idx), 32'd0);
    check("mid_rst_iss",    32'(if_a.iss_valid), 32'd0);
    check("mid_rst_ready",  32'(if_a.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(if_a.in_ready), 32'd1);
    check("post_rst_done0", 32'(if_a.flush_done), 32'd0);
    tick();
    check("post_rst_done1", 32'(if_a.flush_done), 32'd0);

    // ---- bs=16: 40 allocate/issue/retire rounds across the 15->0 wrap ----
    for (int k = 0; k < 40; k++) begin
      check($sformatf("b_wr_idx_%0d", k), 32'(if_b.wr_idx), 32'(k % 16));
      if_b.in_valid = 1'b1;
      tick();
      if_b.in_valid  = 1'b0;
      if_b.iss_ready = 1'b1;
      check($sformatf("b_iss_idx_%0d", k), 32'(if_b.iss_idx), 32'(k % 16));
      tick();
      if_b.iss_ready  = 1'b0;
      if_b.retire_en  = 1'b1;
      if_b.retire_idx = 4'(k % 16);
      tick();
      if_b.retire_en = 1'b0;
    end
    check("b_end_occ",     32'(if_b.occupancy), 32'd0);
    check("b_end_wr_idx",  32'(if_b.wr_idx), 32'd8);
    check("b_end_iss_idx", 32'(if_b.iss_idx), 32'd8);
    check("b_end_err",     32'(if_b.retire_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
